keycode_report_encoder: RTL and testbench

//  Inverse of the keycode-to-button decode: turns five raw game buttons into a
//  32-bit, 4-slot HID-style keycode report (one 8-bit keycode per slot, 00 = empty).

---
 rtl/keycode_report_encoder.sv | 154 +++++++++++++++
 tb/tb_keycode_report_encoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/keycode_report_encoder.sv
// Turns five raw game buttons into a 4-slot, 32-bit HID-style keycode report.
// Pipeline: 2-flop sync -> per-button debounce -> ordered slot list -> valid/ready report register.
module keycode_report_encoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter logic [7:0]  KEY_P1_DIVE     = 8'h1A,
   parameter logic [7:0]  KEY_P1_KICK     = 8'h04,
   parameter logic [7:0]  KEY_P2_DIVE     = 8'h16,
   parameter logic [7:0]  KEY_P2_KICK     = 8'h07,
   parameter logic [7:0]  KEY_START       = 8'h2C
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [4:0]  btn_in,
   input  logic        report_ready,
   output logic [31:0] keycode,
   output logic        report_valid,
   output logic        overflow
);

   localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   function automatic logic [7:0] key_of(input logic [2:0] idx);
      case (idx)
         3'd0:    key_of = KEY_P1_DIVE;
         3'd1:    key_of = KEY_P1_KICK;
         3'd2:    key_of = KEY_P2_DIVE;
         3'd3:    key_of = KEY_P2_KICK;
         3'd4:    key_of = KEY_START;
         default: key_of = 8'h00;
      endcase
   endfunction

   logic [4:0]            sync1_q, sync1_d;
   logic [4:0]            sync2_q, sync2_d;
   logic [4:0]            stable_q, stable_d;
   logic [4:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0][7:0]       slot_q, slot_d;
   logic [2:0]            count_q, count_d;
   logic [4:0]            listed_q, listed_d;
   logic [31:0]           keycode_q, keycode_d;
   logic                  report_valid_q, report_valid_d;
   logic                  overflow_q, overflow_d;

   logic [4:0] remove_mask, append_mask;
   logic       rm_hit, add_hit;
   logic [2:0] rm_idx, add_idx;
   int         rm_pos;

   // Synchroniser and debounce: stable follows synced only after a full run of disagreement.
   always_comb begin
      sync1_d  = btn_in;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = '0;
      for (int i = 0; i < 5; i++) begin
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) stable_d[i] = sync2_q[i];
            else                      cnt_d[i]    = cnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      remove_mask = listed_q & ~stable_q;
      append_mask = stable_q & ~listed_q;
      rm_hit  = 1'b0;
      add_hit = 1'b0;
      rm_idx  = 3'd0;
      add_idx = 3'd0;
      // Scan downwards so the lowest index wins.
      for (int i = 4; i >= 0; i--) begin
         if (remove_mask[i]) begin
            rm_hit = 1'b1;
            rm_idx = 3'(i);
         end
         if (append_mask[i]) begin
            add_hit = 1'b1;
            add_idx = 3'(i);
         end
      end
      rm_pos = 0;
      for (int j = 0; j < 4; j++) begin
         if ((slot_q[j] == key_of(rm_idx)) && (3'(j) < count_q)) rm_pos = j;
      end
   end

   // One reconcile action per cycle: removal beats append, keeping the list contiguous.
   always_comb begin
      slot_d   = slot_q;
      count_d  = count_q;
      listed_d = listed_q;
      if (rm_hit) begin
         for (int j = 0; j < 3; j++) begin
            if (j >= rm_pos) slot_d[j] = slot_q[j+1];
         end
         slot_d[3]        = 8'h00;
         count_d          = count_q - 3'd1;
         listed_d[rm_idx] = 1'b0;
      end else if (add_hit && (count_q < 3'd4)) begin
         slot_d[count_q[1:0]] = key_of(add_idx);
         count_d              = count_q + 3'd1;
         listed_d[add_idx]    = 1'b1;
      end
   end

   always_comb begin
      overflow_d     = (|append_mask) & (count_q == 3'd4);
      keycode_d      = keycode_q;
      report_valid_d = report_valid_q;
      // A stalled report is frozen; once free, publish the latest list if it differs.
      if (!(report_valid_q && !report_ready)) begin
         if (slot_q != keycode_q) begin
            keycode_d      = slot_q;
            report_valid_d = 1'b1;
         end else begin
            report_valid_d = 1'b0;
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values;
   // reset is synchronous, so it is only tested inside the clocked branch.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync1_q        <= '0;
         sync2_q        <= '0;
         stable_q       <= '0;
         cnt_q          <= '0;
         slot_q         <= '0;
         count_q        <= '0;
         listed_q       <= '0;
         keycode_q      <= '0;
         report_valid_q <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         stable_q       <= stable_d;
         cnt_q          <= cnt_d;
         slot_q         <= slot_d;
         count_q        <= count_d;
         listed_q       <= listed_d;
         keycode_q      <= keycode_d;
         report_valid_q <= report_valid_d;
         overflow_q     <= overflow_d;
      end
   end

   assign keycode      = keycode_q;
   assign report_valid = report_valid_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_keycode_report_encoder.sv
// Bench for keycode_report_encoder: directed scenarios plus random button traffic,
// all compared each cycle against a queue-based press-order model.
module tb_keycode_report_encoder;

   localparam int DEB = 16;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [4:0]  btn_in;
   logic        report_ready;
   logic [31:0] keycode;
   logic        report_valid;
   logic        overflow;

   int tests  = 0;
   int fails  = 0;
   int pulses = 0;

   keycode_report_encoder #(.DEBOUNCE_CYCLES(DEB)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .btn_in       (btn_in),
      .report_ready (report_ready),
      .keycode      (keycode),
      .report_valid (report_valid),
      .overflow     (overflow)
   );

   always #5 Clk = ~Clk;

   // Reference model: pressed buttons kept in a queue in press order.
   bit [4:0]    m_s1, m_s2, m_stable;
   int          m_cnt [5];
   int          m_list [$];
   logic [31:0] m_key;
   bit          m_valid, m_ovf;

   function automatic logic [7:0] key_code(input int b);
      case (b)
         0: return 8'h1A;
         1: return 8'h04;
         2: return 8'h16;
         3: return 8'h07;
         default: return 8'h2C;
      endcase
   endfunction

   function automatic bit in_list(input int b);
      foreach (m_list[k]) if (m_list[k] == b) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] list_word();
      logic [31:0] w = '0;
      foreach (m_list[k]) w[8*k +: 8] = key_code(m_list[k]);
      return w;
   endfunction

   always @(posedge Clk) begin
      logic [31:0] lst;
      bit          done, pend;
      if (Reset) begin
         m_s1 = '0; m_s2 = '0; m_stable = '0;
         foreach (m_cnt[i]) m_cnt[i] = 0;
         m_list.delete();
         m_key = '0; m_valid = 1'b0; m_ovf = 1'b0;
      end else begin
         lst = list_word();
         if (!(m_valid && !report_ready)) begin
            if (lst != m_key) begin m_key = lst; m_valid = 1'b1; end
            else m_valid = 1'b0;
         end
         pend = 1'b0;
         for (int i = 0; i < 5; i++) if (m_stable[i] && !in_list(i)) pend = 1'b1;
         m_ovf = pend && (m_list.size() == 4);
         done = 1'b0;
         for (int i = 0; i < 5; i++) begin
            if (!done && !m_stable[i] && in_list(i)) begin
               foreach (m_list[k]) if (m_list[k] == i) begin m_list.delete(k); break; end
               done = 1'b1;
            end
         end
         if (!done && m_list.size() < 4) begin
            for (int i = 0; i < 5; i++) begin
               if (!done && m_stable[i] && !in_list(i)) begin
                  m_list.push_back(i);
                  done = 1'b1;
               end
            end
         end
         for (int i = 0; i < 5; i++) begin
            if (m_s2[i] == m_stable[i]) m_cnt[i] = 0;
            else if (m_cnt[i] == DEB - 1) begin m_stable[i] = m_s2[i]; m_cnt[i] = 0; end
            else m_cnt[i]++;
         end
         m_s2 = m_s1;
         m_s1 = btn_in;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, sample on the falling edge and compare against the model.
   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
      if (report_valid === 1'b1) pulses++;
      check("model_keycode", keycode, m_key);
      check("model_valid", {31'd0, report_valid}, {31'd0, m_valid});
      check("model_overflow", {31'd0, overflow}, {31'd0, m_ovf});
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int first_valid;
      int base;

      Reset = 1'b1; btn_in = '0; report_ready = 1'b1;
      ticks(3);
      check("reset_keycode", keycode, 32'h0);
      check("reset_valid", {31'd0, report_valid}, 32'd0);
      check("reset_overflow", {31'd0, overflow}, 32'd0);
      Reset = 1'b0;

      // Single press: exact 20-cycle latency, one report pulse only.
      pulses = 0; first_valid = 0;
      btn_in = 5'b00001;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (first_valid == 0 && report_valid === 1'b1) first_valid = i;
      end
      check("t1_latency", first_valid, 20);
      ticks(20);
      check("t1_keycode", keycode, 32'h0000001A);
      check("t1_pulses", pulses, 1);

      // Press order and removal with shift-down.
      btn_in = 5'b01001; ticks(25);
      btn_in = 5'b11001; ticks(25);
      check("t2_three", keycode, 32'h002C071A);
      btn_in = 5'b10001; ticks(25);
      check("t2_release", keycode, 32'h00002C1A);
      btn_in = 5'b00000; ticks(25);
      check("t2_empty", keycode, 32'h0);

      // All five at once: ascending order, overflow, auto-append when a slot frees.
      btn_in = 5'b11111; ticks(30);
      check("t3_full", keycode, 32'h0716041A);
      check("t3_ovf", {31'd0, overflow}, 32'd1);
      btn_in = 5'b11101; ticks(30);
      check("t3_refill", keycode, 32'h2C07161A);
      check("t3_ovf_clear", {31'd0, overflow}, 32'd0);
      btn_in = 5'b00000; ticks(30);

      // Bounce shorter than the debounce window is ignored.
      base = pulses;
      for (int i = 0; i < 100; i++) begin
         if (i % 5 == 0) btn_in[2] = ~btn_in[2];
         tick();
      end
      btn_in = '0; ticks(30);
      check("t4_no_report", pulses - base, 0);
      check("t4_keycode", keycode, 32'h0);

      // Back-pressure: report holds, then latest list published after acceptance.
      report_ready = 1'b0;
      btn_in = 5'b00001; ticks(25);
      btn_in = 5'b00011; ticks(25);
      check("t5_hold_key", keycode, 32'h0000001A);
      check("t5_hold_valid", {31'd0, report_valid}, 32'd1);
      report_ready = 1'b1;
      tick();
      check("t5_next_key", keycode, 32'h0000041A);
      check("t5_next_valid", {31'd0, report_valid}, 32'd1);
      btn_in = '0; ticks(30);

      // Reset mid-operation with a button held.
      btn_in = 5'b00001; ticks(25);
      check("t6_before", keycode, 32'h0000001A);
      Reset = 1'b1; tick(); Reset = 1'b0;
      check("t6_key_clr", keycode, 32'h0);
      check("t6_valid_clr", {31'd0, report_valid}, 32'd0);
      check("t6_ovf_clr", {31'd0, overflow}, 32'd0);
      ticks(25);
      check("t6_again", keycode, 32'h0000001A);

      // Random traffic with random back-pressure, short glitches and occasional reset.
      for (int s = 0; s < 80; s++) begin
         int hold;
         btn_in = 5'($urandom);
         hold = $urandom_range(1, 40);
         if ($urandom_range(0, 39) == 0) Reset = 1'b1;
         for (int c = 0; c < hold; c++) begin
            report_ready = ($urandom_range(0, 3) != 0);
            tick();
            Reset = 1'b0;
         end
      end
      report_ready = 1'b1;
      btn_in = '0; ticks(40);
      check("final_empty", keycode, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
